// File: rtl/alu_issue.sv
// Decode/issue sequencer for the embertrail ALU with a 4-entry register file.
// Optional zero-flag output enabled by defining ALU_ISSUE_ZERO_FLAG_EN.
module alu_issue #(
    parameter int DATA_WIDTH  = 16,
    parameter int ALU_LATENCY = 1
) (
    input  logic                  iClock,
    input  logic                  iResetN,
    input  logic                  iInstrValid,
    output logic                  oInstrReady,
    input  logic [15:0]           iInstr,
    output logic [4:0]            oOperation,
    output logic [DATA_WIDTH-1:0] oOperandA,
    output logic [DATA_WIDTH-1:0] oOperandB,
    input  logic [DATA_WIDTH-1:0] iAluResult,
    output logic                  oWbValid,
    output logic [1:0]            oWbReg,
    output logic [DATA_WIDTH-1:0] oWbData,
    output logic                  oBusy
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    ,
    output logic                  oZeroFlag
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    typedef enum logic [2:0] {
        OPC_NOP   = 3'b000,
        OPC_ADD   = 3'b001,
        OPC_XOR   = 3'b010,
        OPC_OR    = 3'b011,
        OPC_NOT   = 3'b100,
        OPC_AND   = 3'b101,
        OPC_MOV   = 3'b110,
        OPC_LOADI = 3'b111
    } opcode_t;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_XOR  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00100;
    localparam logic [4:0] ALU_NOT  = 5'b01000;
    localparam logic [4:0] ALU_AND  = 5'b10000;

    localparam logic [2:0] WAIT_LOAD = (ALU_LATENCY > 1) ? 3'(ALU_LATENCY - 2) : 3'd0;

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   regs [4];

    logic [4:0]              op_q;
    logic [DATA_WIDTH-1:0]   a_q, b_q;
    logic [1:0]              rd_q;

    opcode_t                 opc;
    logic [1:0]              ra, rb;
    logic [4:0]              dec_op;
    logic [DATA_WIDTH-1:0]   dec_a, dec_b;
    logic                    accept;

    assign opc    = opcode_t'(iInstr[15:13]);
    assign ra     = iInstr[10:9];
    assign rb     = iInstr[8:7];
    assign accept = iInstrValid && (state_q == IDLE) && (opc != OPC_NOP);

    // Operands are latched at acceptance; no register write can occur between
    // acceptance and ISSUE, so this equals sampling the file during ISSUE.
    always_comb begin
        dec_op = ALU_NONE;
        dec_a  = '0;
        dec_b  = '0;
        case (opc)
            OPC_ADD: begin dec_op = ALU_ADD; dec_a = regs[ra]; dec_b = regs[rb]; end
            OPC_XOR: begin dec_op = ALU_XOR; dec_a = regs[ra]; dec_b = regs[rb]; end
            OPC_OR:  begin dec_op = ALU_OR;  dec_a = regs[ra]; dec_b = regs[rb]; end
            OPC_NOT: begin dec_op = ALU_NOT; dec_a = regs[ra]; end
            OPC_AND: begin dec_op = ALU_AND; dec_a = regs[ra]; dec_b = regs[rb]; end
            OPC_MOV: dec_b = regs[rb];
            OPC_LOADI: dec_b = DATA_WIDTH'(iInstr[8:0]);
            default: ;
        endcase
    end

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                if (ALU_LATENCY > 1) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = WB;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = WB;
                else             cnt_d   = cnt_q - 3'd1;
            end
            WB: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (accept) begin
                op_q <= dec_op;
                a_q  <= dec_a;
                b_q  <= dec_b;
                rd_q <= iInstr[12:11];
            end
            if (state_q == WB) regs[rd_q] <= iAluResult;
        end
    end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN)           oZeroFlag <= 1'b0;
        else if (state_q == WB) oZeroFlag <= (iAluResult == '0);
    end
`endif

    assign oInstrReady = (state_q == IDLE);
    assign oBusy       = (state_q != IDLE);
    assign oOperation  = (state_q == ISSUE) ? op_q : ALU_NONE;
    assign oOperandA   = a_q;
    assign oOperandB   = b_q;
    assign oWbValid    = (state_q == WB);
    assign oWbReg      = (state_q == WB) ? rd_q : 2'b00;
    assign oWbData     = (state_q == WB) ? iAluResult : '0;

endmodule
